placement_search: RTL
=====================

Name: placement_search

Overview:
- Sequential search engine that drives the combinational board evaluator and reads its score back.
- For one falling piece it enumerates every rotation × left-column placement, hard-drops the piece, and presents each resulting board on eval_board.
- It latches eval_score for each candidate and reports the placement with the lowest signed score (evaluator weights are negated, so lowest is best).
- Sits between the game-state register and the move executor.

Parameters:
- ROWS, 20, board rows; row 0 is the top; column height = ROWS - row index.
- COLS, 10, board columns; cell (r,c) is bit COLS*r + c.
- NUM_ROT, 4, rotations searched per piece.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin search; sampled only in IDLE
- board_in  in  200  current board, captured on accepted start
- piece  in  3  piece code, captured on accepted start: I=0 O=1 T=2 S=3 Z=4 J=5 L=6; 7 is invalid
- eval_board  out  200  candidate board driven to the evaluator
- eval_score  in  32  evaluator result, two's-complement signed, combinational from eval_board
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the search finishes
- best_valid  out  1  at least one legal placement was found
- best_rot  out  2  winning rotation
- best_col  out  4  winning left column of the 4x4 shape box
- best_score  out  32  winning score
- best_board  out  200  winning board, with the piece placed and no line clear applied

Behaviour:
- Reset: rst_n low forces every output and register to 0 and state to IDLE immediately, including mid-search. No partial result survives reset.
- Shape model:
  - 4x4 mask per (piece, rot); bit 4*dy+dx, dy downward, dx rightward, top-normalised.
  - Piece at (y,col) occupies (y+dy, col+dx).
  - A placement fits iff every set cell satisfies col+dx<=9, y+dy<=19, and lands on an empty board cell.
- IDLE: busy=0. start=1 latches board and piece, clears best_*, sets rot=0, col=0, and moves to CHECK. start while busy is ignored.
- CHECK (1 cycle): test fit at y=0.
  - Pass: go to DROP with y=0.
  - Fail (right overflow, spawn collision, or piece=7): go to NEXT.
- DROP: one cycle per probe of y+1.
  - Fits: y++, stay in DROP.
  - Does not fit: go to PLACE.
  - The failing probe costs a cycle. Example: O on an empty board takes 19 DROP cycles.
- PLACE (1 cycle): register eval_board = board | piece cells at (y,col).
- EVAL (1 cycle): sample eval_score from the registered eval_board. Replace best_* if best_valid=0 or $signed(eval_score) < $signed(best_score). Strict less-than means ties keep the earliest candidate (lowest rot, then lowest col).
- NEXT: col++. At col=COLS, reset col=0 and rot++. After rot=NUM_ROT-1, col=9, go to DONE; otherwise go to CHECK.
- DONE (1 cycle): done=1, busy=0, then IDLE. best_* hold their values until the next accepted start.
- Duplicate rotations (O, I, S, Z) are evaluated again; they are not pruned. Ties make them harmless.
- eval_board holds its last value outside PLACE/EVAL. The evaluator output is don't-care except during EVAL.
- Latency: 2 cycles + Σ over candidates of (1 + [fits]·(drops+1+2)) + 1.

Decomposition:
- Shared package tetris_pkg holds:
  - ROWS/COLS constants
  - piece code enum
  - the 7×4 array of 16-bit shape masks
  - a fits(board,mask,y,col) function, which is also used by the bench model
- One sub-module, piece_stamp: combinational fit test plus OR-in of the mask at (y,col). It is reused by CHECK, DROP and PLACE.

Test Plan:
- Empty board, piece O, stub evaluator returns constant 5 -> done, best_valid=1, rot=0, col=0, score=5, best_board bits 180,181,190,191 set only.
- Empty board, piece O, rot0 col0: count cycles from CHECK entry -> exactly 19 DROP cycles before PLACE. Whole search matches the latency formula.
- Stub returns 3 for all candidates except rot=2 col=5, which returns 32'hFFFFFFF0 -> best_rot=2, best_col=5, best_score=32'hFFFFFFF0 (signed compare proven).
- Board with row 0 fully set (bits 0..9), any piece; or piece=7 on an empty board -> done pulse, best_valid=0, best_* all 0, no EVAL cycles.
- Reset mid-DROP: rst_n low for 1 cycle -> busy, done and best_* are 0 in the same cycle. A new start with piece T on an empty board completes normally.
- start pulsed again while busy with a different piece -> ignored; result matches the first piece only. done is a single-cycle pulse.

Source files
------------

// File: rtl/tetris_pkg.sv
// ------------------------------------------------------------------
// tetris_pkg: board geometry, piece codes, shape masks, fit test
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package tetris_pkg;

  localparam int ROWS    = 20;
  localparam int COLS    = 10;
  localparam int NUM_ROT = 4;
  localparam int BOARD_W = ROWS * COLS;

  typedef enum logic [2:0] {
    PIECE_I   = 3'd0,
    PIECE_O   = 3'd1,
    PIECE_T   = 3'd2,
    PIECE_S   = 3'd3,
    PIECE_Z   = 3'd4,
    PIECE_J   = 3'd5,
    PIECE_L   = 3'd6,
    PIECE_BAD = 3'd7
  } piece_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_DROP  = 3'd2,
    ST_PLACE = 3'd3,
    ST_EVAL  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Bit 4*dy+dx of each mask; every shape is top- and left-normalised.
  localparam logic [15:0] SHAPES [0:6][0:3] = '{
    '{16'h000F, 16'h1111, 16'h000F, 16'h1111},  // I
    '{16'h0033, 16'h0033, 16'h0033, 16'h0033},  // O
    '{16'h0072, 16'h0131, 16'h0027, 16'h0232},  // T
    '{16'h0036, 16'h0231, 16'h0036, 16'h0231},  // S
    '{16'h0063, 16'h0132, 16'h0063, 16'h0132},  // Z
    '{16'h0071, 16'h0113, 16'h0047, 16'h0322},  // J
    '{16'h0074, 16'h0311, 16'h0017, 16'h0223}   // L
  };

  function automatic logic [15:0] shape_mask(input piece_t p, input logic [1:0] r);
    logic [15:0] m;
    m = 16'h0000;
    if (p != PIECE_BAD) m = SHAPES[p][r];
    return m;
  endfunction

  // An empty mask (invalid piece) never fits.
  function automatic logic fits(input logic [BOARD_W-1:0] board, input logic [15:0] mask,
                                input int y, input int col);
    logic ok;
    ok = (mask != 16'h0000);
    for (int dy = 0; dy < 4; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        if (mask[4*dy+dx]) begin
          if ((col + dx >= COLS) || (y + dy >= ROWS)) ok = 1'b0;
          else if (board[COLS*(y+dy) + col + dx]) ok = 1'b0;
        end
      end
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/placement_search_if.sv
// ------------------------------------------------------------------
// placement_search_if: request/result and evaluator bus of the search
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface placement_search_if #(
  parameter int ROWS = 20,
  parameter int COLS = 10
);
  localparam int BW = ROWS * COLS;

  logic          start;
  logic [BW-1:0] board_in;
  logic [2:0]    piece;
  logic [BW-1:0] eval_board;
  logic [31:0]   eval_score;
  logic          busy;
  logic          done;
  logic          best_valid;
  logic [1:0]    best_rot;
  logic [3:0]    best_col;
  logic [31:0]   best_score;
  logic [BW-1:0] best_board;

  // master: game state side plus the board evaluator
  modport master (
    output start, board_in, piece, eval_score,
    input  eval_board, busy, done, best_valid, best_rot, best_col, best_score, best_board
  );

  modport slave (
    input  start, board_in, piece, eval_score,
    output eval_board, busy, done, best_valid, best_rot, best_col, best_score, best_board
  );
endinterface

`default_nettype wire

// File: rtl/piece_stamp.sv
// ------------------------------------------------------------------
// piece_stamp: fit test and OR-in of a 4x4 shape mask at (y,col)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module piece_stamp
  import tetris_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [15:0]        mask,
  input  logic [4:0]         y,
  input  logic [3:0]         col,
  output logic               fit,
  output logic [BOARD_W-1:0] stamped
);

  assign fit = fits(board, mask, int'(y), int'(col));

  // Cells falling outside the board are dropped; callers only use the
  // stamped board for placements that already passed the fit test.
  always_comb begin
    stamped = board;
    for (int dy = 0; dy < 4; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        if (mask[4*dy+dx] && (int'(col) + dx < COLS) && (int'(y) + dy < ROWS))
          stamped[COLS*(int'(y)+dy) + int'(col) + dx] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/placement_search.sv
// ------------------------------------------------------------------
// placement_search: rotation x column hard-drop search, lowest score wins
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module placement_search #(
  parameter int ROWS    = tetris_pkg::ROWS,
  parameter int COLS    = tetris_pkg::COLS,
  parameter int NUM_ROT = tetris_pkg::NUM_ROT
) (
  input  logic              clk,
  input  logic              rst_n,
  placement_search_if.slave bus
);
  import tetris_pkg::*;

  localparam int         BW       = ROWS * COLS;
  localparam logic [1:0] LAST_ROT = 2'(NUM_ROT - 1);
  localparam logic [3:0] LAST_COL = 4'(COLS - 1);

  state_t        state, state_nx;
  logic [BW-1:0] board_q;
  logic [BW-1:0] eval_board_q;
  logic [BW-1:0] best_board_q;
  piece_t        piece_q;
  logic [1:0]    rot_q;
  logic [1:0]    best_rot_q;
  logic [3:0]    col_q;
  logic [3:0]    best_col_q;
  logic [4:0]    y_q;
  logic [4:0]    probe_y;
  logic [15:0]   mask;
  logic [31:0]   best_score_q;
  logic          best_valid_q;
  logic          fit;
  logic          advance;
  logic          last_cand;
  logic          better;
  logic [BW-1:0] stamped;

  assign mask      = shape_mask(piece_q, rot_q);
  assign last_cand = (rot_q == LAST_ROT) && (col_q == LAST_COL);
  assign better    = !best_valid_q || ($signed(bus.eval_score) < $signed(best_score_q));

  // One stamper serves spawn test, drop probe and final placement.
  always_comb begin
    probe_y = y_q;
    if (state == ST_CHECK)     probe_y = 5'd0;
    else if (state == ST_DROP) probe_y = y_q + 5'd1;
  end

  piece_stamp u_stamp (
    .board   (board_q),
    .mask    (mask),
    .y       (probe_y),
    .col     (col_q),
    .fit     (fit),
    .stamped (stamped)
  );

  // Moving to the next candidate happens on the exit edge of CHECK or
  // EVAL, so it costs no cycle of its own.
  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    case (state)
      ST_IDLE:  if (bus.start) state_nx = ST_CHECK;
      ST_CHECK: begin
        if (fit) state_nx = ST_DROP;
        else     advance  = 1'b1;
      end
      ST_DROP:  if (!fit) state_nx = ST_PLACE;
      ST_PLACE: state_nx = ST_EVAL;
      ST_EVAL:  advance  = 1'b1;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if (advance) state_nx = last_cand ? ST_DONE : ST_CHECK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_q      <= '0;
      piece_q      <= PIECE_I;
      rot_q        <= '0;
      col_q        <= '0;
      y_q          <= '0;
      eval_board_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            board_q <= bus.board_in;
            piece_q <= piece_t'(bus.piece);
            rot_q   <= '0;
            col_q   <= '0;
            y_q     <= '0;
          end
        end
        ST_CHECK: y_q <= 5'd0;
        ST_DROP:  if (fit) y_q <= y_q + 5'd1;
        ST_PLACE: eval_board_q <= stamped;
        default: ;
      endcase
      if (advance) begin
        if (col_q == LAST_COL) begin
          col_q <= '0;
          rot_q <= rot_q + 2'd1;
        end else begin
          col_q <= col_q + 4'd1;
        end
      end
    end
  end

  // Strict less-than: ties keep the earliest candidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_valid_q <= 1'b0;
      best_rot_q   <= '0;
      best_col_q   <= '0;
      best_score_q <= '0;
      best_board_q <= '0;
    end else if (state == ST_IDLE && bus.start) begin
      best_valid_q <= 1'b0;
      best_rot_q   <= '0;
      best_col_q   <= '0;
      best_score_q <= '0;
      best_board_q <= '0;
    end else if (state == ST_EVAL && better) begin
      best_valid_q <= 1'b1;
      best_rot_q   <= rot_q;
      best_col_q   <= col_q;
      best_score_q <= bus.eval_score;
      best_board_q <= eval_board_q;
    end
  end

  assign bus.eval_board = eval_board_q;
  assign bus.busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign bus.done       = (state == ST_DONE);
  assign bus.best_valid = best_valid_q;
  assign bus.best_rot   = best_rot_q;
  assign bus.best_col   = best_col_q;
  assign bus.best_score = best_score_q;
  assign bus.best_board = best_board_q;

endmodule

`default_nettype wire
